// File: rtl/prio_arb_pkg.sv
// prio_arb_pkg: shared FSM state type and arbitration mode constants for prio_enc_arb.
package prio_arb_pkg;

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_enc_rot.sv
// prio_enc_rot: combinational rotating priority finder; index k-1 has highest priority, k lowest.
module prio_enc_rot #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] k,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] pos;

    function automatic logic [IDX_W-1:0] wrap_add(input int a, input int b);
        int s;
        s = a + b;
        return IDX_W'((s >= N) ? s - N : s);
    endfunction

    // Rotate so requester k-1 lands on the top bit, find the highest set bit, then map it back.
    always_comb begin
        rot = '0;
        pos = '0;
        for (int j = 0; j < N; j++) begin
            rot[j] = req[wrap_add(j, int'(k))];
        end
        for (int j = 0; j < N; j++) begin
            if (rot[j]) pos = IDX_W'(j);
        end
        found = |req;
        idx   = wrap_add(int'(pos), int'(k));
    end

endmodule

// File: rtl/prio_enc_arb.sv
// prio_enc_arb: N-input fixed/round-robin arbiter with registered grant and valid/ready handshake.
// Optional saturating accept counter is enabled by defining PRIO_ARB_STATS_EN.
module prio_enc_arb
    import prio_arb_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             gnt_ready,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N-1:0]     gnt_onehot
`ifdef PRIO_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] accept_cnt
`endif
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [N-1:0]     gnt_onehot_q, gnt_onehot_d;
    logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
    logic [IDX_W-1:0] arb_k;
    logic [IDX_W-1:0] win_idx;
    logic             found;
    logic             accept;

    assign accept = (state_q == ST_GRANT) && gnt_ready;

    // Pointer moves to the accepted index; re-arbitration in the same cycle already sees it.
    always_comb begin
        last_ptr_d = accept ? gnt_idx_q : last_ptr_q;
        arb_k      = (mode == MODE_RR) ? last_ptr_d : '0;
    end

    prio_enc_rot #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rot (
        .req   (req),
        .k     (arb_k),
        .found (found),
        .idx   (win_idx)
    );

    // Arbitrate when idle or on accept; otherwise hold the grant regardless of req/mode.
    always_comb begin
        state_d      = state_q;
        gnt_idx_d    = gnt_idx_q;
        gnt_onehot_d = gnt_onehot_q;
        if (state_q == ST_IDLE || accept) begin
            state_d      = found ? ST_GRANT : ST_IDLE;
            gnt_idx_d    = found ? win_idx : '0;
            gnt_onehot_d = found ? (N'(1) << win_idx) : '0;
        end
    end

    // State and grant registers; reset clears any pending grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
            last_ptr_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_onehot_q <= gnt_onehot_d;
            last_ptr_q   <= last_ptr_d;
        end
    end

    assign gnt_valid  = (state_q == ST_GRANT);
    assign gnt_idx    = gnt_idx_q;
    assign gnt_onehot = gnt_onehot_q;

`ifdef PRIO_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count accepts, sticking at all-ones.
    always_comb begin
        cnt_d = (accept && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Accept counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign accept_cnt = cnt_q;
`endif

endmodule
